wb_dmem_slave: RTL
==================

Name: wb_dmem_slave

Overview:
- Pipelined Wishbone data-memory slave.
- Sits directly downstream of the CPU core's data port and consumes its CYC/STB/WE/ADR/DAT request stream.
- Returns ACK/ERR and read data; drives STALL back for flow control.
- Holds an internal word-addressed RAM with a configurable response latency and a bounded number of outstanding requests.

Parameters:
- ADDR_W, 32, byte-address width of ADR_I.
- DATA_W, 32, data width.
- MEM_WORDS, 1024, RAM depth in words (power of two).
- WS, 1, extra wait states; response latency = 1+WS cycles (0..3).
- MAX_OUTST, 2, maximum accepted-but-unanswered requests (1..4).

Ports:
- CLK_I  in  1  clock; all state on rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- CYC_I  in  1  bus cycle active.
- STB_I  in  1  request strobe.
- WE_I  in  1  1 = write, 0 = read.
- LOCK_I  in  1  locked cycle; accepted, no functional effect.
- ADR_I  in  ADDR_W  byte address.
- DAT_I  in  DATA_W  write data.
- DAT_O  out  DATA_W  read data, valid with ACK_O on reads.
- ACK_O  out  1  successful completion, one pulse per accepted good request.
- ERR_O  out  1  error completion, one pulse per accepted bad request.
- STALL_O  out  1  request not accepted this cycle.

Behaviour:
- Reset (RST_I=0, asynchronous):
  - ACK_O=0, ERR_O=0, DAT_O=0, STALL_O=0.
  - Outstanding counter=0; response pipeline cleared.
  - RAM contents undefined/unchanged.
- Accept: cycle where CYC_I & STB_I & !STALL_O. At most one accept per cycle.
- Bad request: ADR_I[1:0]!=0 or word index ADR_I>>2 >= MEM_WORDS.
  - RAM is not written.
  - Completes with ERR_O instead of ACK_O.
- Write:
  - A good write updates RAM[ADR_I>>2] at the accept edge.
  - ACK_O after the normal latency; DAT_O=0 on write ACKs.
- Read:
  - RAM is read at accept; data carried through the response pipeline.
  - DAT_O valid in the same cycle as ACK_O.
- Latency: request accepted at edge N gives ACK_O/ERR_O high for exactly one cycle after edge N+1+WS. Responses are strictly in acceptance order.
- Response pipeline: a shift register of 1+WS stages. Each stage holds {valid, err, rdata}. It shifts every cycle.
- Outstanding counter:
  - +1 on accept, −1 on response emit; both in the same cycle leaves it unchanged.
  - Range 0..MAX_OUTST.
- STALL_O (combinational from registered state) = (count==MAX_OUTST) & !(response emitted this cycle).
  - When the count is at the limit and a response retires in the same cycle, a new request is accepted: no bubble.
  - If MAX_OUTST >= 1+WS, STALL_O never asserts.
- Read-after-write:
  - Write at N followed by a read of the same address at N+1 returns the new data.
  - A read and a write accepted in the same cycle cannot occur (single port).
- CYC_I deassert (abort):
  - All pipeline valid bits are cleared on the next edge and the counter is zeroed.
  - No ACK_O/ERR_O is emitted for aborted requests.
  - Writes already performed remain in RAM.
- STB_I while CYC_I=0 is ignored.
- Reset mid-transfer: all pending responses are dropped immediately; no ACK/ERR is emitted after reset release until new requests are accepted.

Test Plan:
1. WS=1, MAX_OUTST=2. Write 0xDEADBEEF @0x10, then read @0x10 back-to-back → write ACK at accept+2, read ACK at accept+3 with DAT_O=0xDEADBEEF; STALL_O stays 0.
2. WS=1, MAX_OUTST=1. STB_I held with 4 reads @0x0,0x4,0x8,0xC → STALL_O high on every other cycle; 4 ACKs in order with correct data; no request lost or duplicated.
3. Read @0x2 (misaligned), then write @(MEM_WORDS*4) → two ERR_O pulses, no ACK_O; a subsequent read of word 0 shows unchanged contents.
4. Accept 2 reads, then drop CYC_I the next cycle → no ACK_O/ERR_O afterwards; counter returns to 0; a new request is accepted immediately with STALL_O=0.
5. Assert RST_I=0 asynchronously mid-burst, between clock edges → outputs go to 0 immediately; after release a read @0x10 returns the value written before reset.
6. WS=0, MAX_OUTST=1. Continuous alternating write/read of 16 addresses → one transfer per cycle, ACK one cycle after accept, all read data matches.

Source files
------------

// File: rtl/wb_dmem_slave.sv
// Pipelined Wishbone data-memory slave: word RAM, fixed 1+WS response latency,
// in-order responses, bounded outstanding requests with STALL_O flow control.
module wb_dmem_slave #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned WS        = 1,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic              LOCK_I,
  input  logic [ADDR_W-1:0] ADR_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic [DATA_W-1:0] DAT_O,
  output logic              ACK_O,
  output logic              ERR_O,
  output logic              STALL_O
);

  localparam int unsigned NSTG  = WS + 1;
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  rsp_t              pipe_q [NSTG];
  rsp_t              pipe_d [NSTG];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  logic              accept_c;
  logic              bad_c;
  logic              emit_c;
  logic [IDX_W-1:0]  idx_c;
  logic              unused_lock;

  // Locked cycles are accepted like any other request.
  assign unused_lock = LOCK_I;

  assign idx_c    = ADR_I[IDX_W+1:2];
  assign bad_c    = (ADR_I[1:0] != 2'b00) || ((ADR_I >> 2) >= ADDR_W'(MEM_WORDS));
  // The last stage retires into the output register on the coming edge, freeing a slot.
  assign emit_c   = pipe_q[NSTG-1].valid;
  assign STALL_O  = (cnt_q == CNT_W'(MAX_OUTST)) && !emit_c;
  assign accept_c = CYC_I && STB_I && !STALL_O;

  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign DAT_O = dat_q;

  // Response shift register, outstanding count and output staging.
  always_comb begin
    cnt_d = cnt_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = '0;
    for (int i = 0; i < int'(NSTG); i++) pipe_d[i] = '0;

    pipe_d[0].valid = accept_c;
    pipe_d[0].err   = bad_c;
    pipe_d[0].rdata = (accept_c && !WE_I && !bad_c) ? mem_q[idx_c] : '0;
    for (int i = 1; i < int'(NSTG); i++) pipe_d[i] = pipe_q[i-1];

    if (emit_c) begin
      ack_d = !pipe_q[NSTG-1].err;
      err_d = pipe_q[NSTG-1].err;
      dat_d = pipe_q[NSTG-1].rdata;
    end
    cnt_d = cnt_q + CNT_W'(accept_c) - CNT_W'(emit_c);

    // Dropping CYC_I abandons every request still in flight.
    if (!CYC_I) begin
      for (int i = 0; i < int'(NSTG); i++) pipe_d[i].valid = 1'b0;
      cnt_d = '0;
      ack_d = 1'b0;
      err_d = 1'b0;
      dat_d = '0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      for (int i = 0; i < int'(NSTG); i++) pipe_q[i] <= '0;
      cnt_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      dat_q  <= dat_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge CLK_I) begin
    if (accept_c && WE_I && !bad_c) mem_q[idx_c] <= DAT_I;
  end

endmodule
